// File: rtl/wshb_arb_pkg.sv
// Shared types and default sizes for the two-master Wishbone arbiter.
package wshb_arb_pkg;

    // Bus ownership: nobody, master 0 (video read), master 1 (pixel writer).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int DEF_AW         = 32;
    localparam int DEF_DW         = 32;
    localparam int DEF_STARVE_MAX = 4096;

    // Width and ceiling of the per-owner outstanding-strobe counter.
    localparam int         OUT_W   = 8;
    localparam logic [7:0] OUT_MAX = 8'hFF;

endpackage

// File: rtl/wshb_arbiter_rr_picker2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// master that was not served last.
module rr_picker2
    import wshb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    // Pure combinational pick; no state lives here.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        valid  = |req;
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone B4 pipelined arbiter in front of the SDRAM bridge.
// Grants are held for the winner's whole CYC; the owner is wired straight
// through to the slave so no bus latency is added beyond the grant itself.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STARVE_MAX = DEF_STARVE_MAX
)(
    input  logic            clk,
    input  logic            rst_n,

    input  logic            m0_cyc,
    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW-1:0]   m0_dat_w,
    input  logic [DW/8-1:0] m0_sel,
    output logic            m0_ack,
    output logic            m0_stall,
    output logic [DW-1:0]   m0_dat_r,

    input  logic            m1_cyc,
    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW-1:0]   m1_dat_w,
    input  logic [DW/8-1:0] m1_sel,
    output logic            m1_ack,
    output logic            m1_stall,
    output logic [DW-1:0]   m1_dat_r,

    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_dat_w,
    output logic [DW/8-1:0] s_sel,
    input  logic            s_ack,
    input  logic            s_stall,
    input  logic [DW-1:0]   s_dat_r,

    output logic [1:0]      grant,
    output logic [OUT_W-1:0] outstanding,
    output logic [1:0]      starve
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] WAIT_SAT = SW'(STARVE_MAX);
    localparam logic [SW-1:0] WAIT_PRE = SW'(STARVE_MAX - 1);

    arb_state_t state;
    logic       last;
    logic [1:0] req;
    logic       owner_cyc;
    logic       arbitrate;
    logic       winner;
    logic       win_valid;
    logic       accept;
    logic       retire;

    assign req       = {m1_cyc, m0_cyc};
    assign grant     = {state == OWN1, state == OWN0};
    assign arbitrate = (state == IDLE) || !owner_cyc;
    assign accept    = s_stb & ~s_stall;
    // An ack with nothing outstanding is a stray and must not underflow.
    assign retire    = s_ack & (outstanding != '0);

    rr_picker2 u_picker (
        .req    (req),
        .last   (last),
        .winner (winner),
        .valid  (win_valid)
    );

    // Steer the owner's request to the slave and the slave's response back
    // to the owner; the non-owner sees a permanently stalled, silent bus.
    always_comb begin
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        s_we      = 1'b0;
        s_adr     = '0;
        s_dat_w   = '0;
        s_sel     = '0;
        m0_ack    = 1'b0;
        m0_stall  = 1'b1;
        m0_dat_r  = '0;
        m1_ack    = 1'b0;
        m1_stall  = 1'b1;
        m1_dat_r  = '0;
        owner_cyc = 1'b0;
        case (state)
            OWN0: begin
                s_cyc     = m0_cyc;
                s_stb     = m0_stb;
                s_we      = m0_we;
                s_adr     = m0_adr;
                s_dat_w   = m0_dat_w;
                s_sel     = m0_sel;
                m0_ack    = s_ack;
                m0_stall  = s_stall;
                m0_dat_r  = s_dat_r;
                owner_cyc = m0_cyc;
            end
            OWN1: begin
                s_cyc     = m1_cyc;
                s_stb     = m1_stb;
                s_we      = m1_we;
                s_adr     = m1_adr;
                s_dat_w   = m1_dat_w;
                s_sel     = m1_sel;
                m1_ack    = s_ack;
                m1_stall  = s_stall;
                m1_dat_r  = s_dat_r;
                owner_cyc = m1_cyc;
            end
            default: ;
        endcase
    end

    // Ownership FSM with round-robin memory and the owner's in-flight count.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            outstanding <= '0;
        end else if (arbitrate) begin
            // Owner released (or bus idle): hand over with no idle gap.
            outstanding <= '0;
            if (win_valid) begin
                state <= winner ? OWN1 : OWN0;
                last  <= winner;
            end else begin
                state <= IDLE;
            end
        end else begin
            if (accept && !retire && outstanding != OUT_MAX)
                outstanding <= outstanding + 8'd1;
            else if (retire && !accept)
                outstanding <= outstanding - 8'd1;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_starve
        logic [SW-1:0] wait_cnt;
        logic          flag;

        // Count cycles this master waits with CYC up and no grant; the flag
        // latches on reaching the limit and holds until reset.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wait_cnt <= '0;
                flag     <= 1'b0;
            end else if (req[i] && !grant[i]) begin
                if (wait_cnt != WAIT_SAT)
                    wait_cnt <= wait_cnt + SW'(1);
                if (wait_cnt >= WAIT_PRE)
                    flag <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end

        assign starve[i] = flag;
    end

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter with a behavioural ownership model that is
// compared against the DUT on every falling edge.
module tb_wshb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4096;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            m0_cyc, m0_stb, m0_we;
    logic [AW-1:0]   m0_adr;
    logic [DW-1:0]   m0_dat_w;
    logic [DW/8-1:0] m0_sel;
    logic            m0_ack, m0_stall;
    logic [DW-1:0]   m0_dat_r;
    logic            m1_cyc, m1_stb, m1_we;
    logic [AW-1:0]   m1_adr;
    logic [DW-1:0]   m1_dat_w;
    logic [DW/8-1:0] m1_sel;
    logic            m1_ack, m1_stall;
    logic [DW-1:0]   m1_dat_r;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_w;
    logic [DW/8-1:0] s_sel;
    logic            s_ack, s_stall;
    logic [DW-1:0]   s_dat_r;
    logic [1:0]      grant;
    logic [7:0]      outstanding;
    logic [1:0]      starve;

    int pass_cnt  = 0;
    int total_cnt = 0;

    wshb_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_ack(m0_ack),
        .m0_stall(m0_stall), .m0_dat_r(m0_dat_r),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_ack(m1_ack),
        .m1_stall(m1_stall), .m1_dat_r(m1_dat_r),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_w(s_dat_w), .s_sel(s_sel), .s_ack(s_ack),
        .s_stall(s_stall), .s_dat_r(s_dat_r),
        .grant(grant), .outstanding(outstanding), .starve(starve)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // ---------------- behavioural model ----------------
    // own: -1 = nobody, else index of the master holding the bus.
    int       own    = -1;
    int       last_m = 1;
    int       outst  = 0;
    int       wcnt[2];
    bit [1:0] flag;
    bit [1:0] cyc_s;
    bit       acc, ak;
    bit       cmp_en = 1'b0;

    always @(posedge clk) begin
        cyc_s = {m1_cyc, m0_cyc};
        if (!rst_n) begin
            own    = -1;
            last_m = 1;
            outst  = 0;
            wcnt[0] = 0;
            wcnt[1] = 0;
            flag   = 2'b00;
            cmp_en = 1'b1;
        end else begin
            if (own >= 0 && outst != 0)
                assert (cyc_s[own])
                else $error("protocol: master %0d dropped cyc with %0d in flight", own, outst);
            for (int i = 0; i < 2; i++) begin
                if (cyc_s[i] && own != i) begin
                    if (wcnt[i] < SM) wcnt[i]++;
                    if (wcnt[i] >= SM) flag[i] = 1'b1;
                end else begin
                    wcnt[i] = 0;
                end
            end
            if (own < 0 || !cyc_s[own]) begin
                outst = 0;
                if (cyc_s == 2'b11)  own = 1 - last_m;
                else if (cyc_s[0])   own = 0;
                else if (cyc_s[1])   own = 1;
                else                 own = -1;
                if (own >= 0) last_m = own;
            end else begin
                acc = ((own == 0) ? m0_stb : m1_stb) && !s_stall;
                ak  = s_ack && (outst > 0);
                if (acc && !ak) outst = (outst < 255) ? outst + 1 : 255;
                else if (ak && !acc) outst = outst - 1;
            end
        end
    end

    logic [1:0]  exp_grant;
    logic [70:0] exp_s;
    logic [33:0] exp_m0, exp_m1;

    // Full-output comparison against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            exp_grant = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
            if (own == 0)      exp_s = {m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_w, m0_sel};
            else if (own == 1) exp_s = {m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_w, m1_sel};
            else               exp_s = '0;
            exp_m0 = (own == 0) ? {s_ack, s_stall, s_dat_r} : {1'b0, 1'b1, 32'h0};
            exp_m1 = (own == 1) ? {s_ack, s_stall, s_dat_r} : {1'b0, 1'b1, 32'h0};
            check("cmp_grant", 128'(grant), 128'(exp_grant));
            check("cmp_outstanding", 128'(outstanding), 128'(outst[7:0]));
            check("cmp_starve", 128'(starve), 128'(flag));
            check("cmp_slave_bus", 128'({s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel}), 128'(exp_s));
            check("cmp_m0_resp", 128'({m0_ack, m0_stall, m0_dat_r}), 128'(exp_m0));
            check("cmp_m1_resp", 128'({m1_ack, m1_stall, m1_dat_r}), 128'(exp_m1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_masters();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_w = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_w = '0; m1_sel = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_masters();
        s_ack = 0; s_stall = 0; s_dat_r = '0;
        tick(1);
        rst_n = 1;
    endtask

    int exp_out[10] = '{0, 0, 1, 2, 3, 4, 3, 2, 1, 0};

    initial begin
        rst_n = 0;
        idle_masters();
        s_ack = 0; s_stall = 0; s_dat_r = '0;
        tick(3);
        check("rst_grant", 128'(grant), 128'(2'b00));
        check("rst_outstanding", 128'(outstanding), 128'(0));
        check("rst_starve", 128'(starve), 128'(2'b00));
        check("rst_stalls", 128'({m0_stall, m1_stall}), 128'(2'b11));
        check("rst_s_cyc", 128'({s_cyc, s_stb}), 128'(2'b00));
        rst_n = 1;
        tick(1);

        // Lone master 0: one-cycle grant latency, single write.
        m0_cyc = 1;
        check("t1_no_grant_yet", 128'(grant), 128'(2'b00));
        tick(1);
        check("t1_grant", 128'(grant), 128'(2'b01));
        check("t1_m1_stall", 128'(m1_stall), 128'(1));
        m0_stb = 1; m0_we = 1; m0_adr = 32'h0000_0040; m0_dat_w = 32'hCAFE_0001; m0_sel = 4'hF;
        #1;
        check("t1_s_adr", 128'(s_adr), 128'(32'h0000_0040));
        tick(1);
        check("t1_out1", 128'(outstanding), 128'(1));
        m0_stb = 0; s_ack = 1; s_dat_r = 32'h1234_5678;
        #1;
        check("t1_m0_dat_r", 128'(m0_dat_r), 128'(32'h1234_5678));
        check("t1_m1_ack", 128'(m1_ack), 128'(0));
        tick(1);
        check("t1_out0", 128'(outstanding), 128'(0));
        s_ack = 0; s_dat_r = '0; m0_cyc = 0; m0_we = 0;
        tick(1);
        check("t1_idle", 128'(grant), 128'(2'b00));

        // Ties: master 0 first after reset, seamless handover, round robin.
        do_reset();
        m0_cyc = 1; m1_cyc = 1;
        tick(1);
        check("t2_tie_first", 128'(grant), 128'(2'b01));
        m0_cyc = 0;
        tick(1);
        check("t2_handover", 128'(grant), 128'(2'b10));
        m1_cyc = 0;
        tick(1);
        check("t2_idle", 128'(grant), 128'(2'b00));
        m0_cyc = 1; m1_cyc = 1;
        tick(1);
        check("t2_tie_second", 128'(grant), 128'(2'b01));
        m0_cyc = 0;
        tick(1);
        check("t2_handover2", 128'(grant), 128'(2'b10));
        m1_cyc = 0;
        tick(1);

        // Master 1 pipelined burst of four, two stall cycles, delayed acks.
        do_reset();
        m1_cyc = 1;
        tick(1);
        check("t3_grant_m1", 128'(grant), 128'(2'b10));
        m0_cyc = 1;
        for (int e = 0; e < 10; e++) begin
            m1_stb  = (e <= 5);
            m1_sel  = 4'hF;
            m1_adr  = 32'h0000_0100 + 32'(4 * ((e <= 2) ? 0 : (e <= 5 ? e - 2 : 3)));
            s_stall = (e <= 1);
            s_ack   = (e >= 6);
            s_dat_r = (e >= 6) ? 32'hD000_0000 + 32'(e) : 32'h0;
            tick(1);
            check($sformatf("t3_out_e%0d", e), 128'(outstanding), 128'(exp_out[e]));
        end
        m1_stb = 0; s_ack = 0; s_dat_r = '0; m1_cyc = 0;
        tick(1);
        check("t3_m0_next", 128'(grant), 128'(2'b01));
        m0_cyc = 0;
        tick(1);
        check("t3_idle", 128'(grant), 128'(2'b00));

        // Counter corner cases: stray ack, simultaneous accept+ack, ceiling.
        m0_cyc = 1;
        tick(1);
        s_ack = 1;
        tick(1);
        check("t6_ack_at_zero", 128'(outstanding), 128'(0));
        s_ack = 0; m0_stb = 1; m0_adr = 32'h0000_0200;
        tick(2);
        check("t6_out2", 128'(outstanding), 128'(2));
        s_ack = 1;
        tick(1);
        check("t6_accept_and_ack", 128'(outstanding), 128'(2));
        m0_stb = 0;
        tick(2);
        check("t6_drained", 128'(outstanding), 128'(0));
        s_ack = 0; m0_cyc = 0;
        tick(1);
        m0_cyc = 1; m0_stb = 1;
        tick(1);
        tick(258);
        check("t6_saturate", 128'(outstanding), 128'(255));
        do_reset();
        check("t6_reset_clears", 128'(outstanding), 128'(0));

        // Reset in the middle of a burst with three strobes in flight.
        m0_cyc = 1;
        tick(1);
        m0_stb = 1;
        tick(3);
        check("t5_out3", 128'(outstanding), 128'(3));
        rst_n = 0; m0_cyc = 0; m0_stb = 0;
        tick(1);
        check("t5_grant", 128'(grant), 128'(2'b00));
        check("t5_outstanding", 128'(outstanding), 128'(0));
        check("t5_s_cyc", 128'(s_cyc), 128'(0));
        check("t5_stalls", 128'({m0_stall, m1_stall}), 128'(2'b11));
        rst_n = 1;
        tick(1);

        // Starvation: master 0 hogs the bus while master 1 waits.
        m0_cyc = 1;
        tick(1);
        m1_cyc = 1;
        tick(SM - 1);
        check("t4_not_yet", 128'(starve), 128'(2'b00));
        tick(1);
        check("t4_starved", 128'(starve), 128'(2'b10));
        tick(900);
        m0_cyc = 0;
        tick(1);
        check("t4_m1_granted", 128'(grant), 128'(2'b10));
        check("t4_sticky", 128'(starve), 128'(2'b10));
        m1_cyc = 0;
        tick(2);
        check("t4_sticky_idle", 128'(starve), 128'(2'b10));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wshb_arbiter.md
Name: wshb_arbiter

Overview:
- Two-master Wishbone B4 pipelined arbiter that shares the single SDRAM/framebuffer slave port.
- Master 0 is the video read path (display FIFO fill); master 1 is the pixel writer (test-pattern generator / frame writer).
- Round-robin, cycle-granular arbitration: a grant is held for the full duration of the winner's CYC.
- Sits in Top between the two masters and the SDRAM bridge, in the system clock domain.

Parameters:
- AW, 32, address width
- DW, 32, data width (SEL width = DW/8)
- STARVE_MAX, 4096, wait cycles with CYC high and no grant before a master's starve flag is set

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 bus cycle, strobe, write enable
- m0_adr  in  AW  master 0 address
- m0_dat_w  in  DW  master 0 write data
- m0_sel  in  DW/8  master 0 byte select
- m0_ack, m0_stall  out  1 each  master 0 acknowledge, stall
- m0_dat_r  out  DW  master 0 read data
- m1_*  same set as m0_*, for master 1
- s_cyc, s_stb, s_we  out  1 each  to slave
- s_adr  out  AW  to slave
- s_dat_w  out  DW  to slave
- s_sel  out  DW/8  to slave
- s_ack, s_stall  in  1 each  from slave
- s_dat_r  in  DW  from slave
- grant  out  2  one-hot current owner (00 = idle)
- outstanding  out  8  accepted strobes not yet acked, for the current owner
- starve  out  2  sticky per-master starvation flags

Behaviour:
- FSM states: IDLE, OWN0, OWN1. Registered state; grant = {state==OWN1, state==OWN0}.
- Round-robin pointer last (1 bit), holds the last master served. Reset value 1, so master 0 wins the first tie.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, last=1, outstanding=0, starve=00, both wait counters=0.
  - All s_* outputs 0; m*_ack=0; m*_stall=1; m*_dat_r=0.
  - Reset mid-transfer abandons the cycle with no handshake; the masters are reset by the same rst_n.
- Arbitration: performed when state=IDLE, or when the current owner's cyc=0 in that cycle.
  - Only one master requesting (cyc=1): it wins.
  - Both requesting: the master != last wins.
  - Neither requesting: next state is IDLE.
  - The new grant takes effect on the next edge. Latency from cyc rise to grant is 1 cycle when the bus is idle.
  - No idle gap when ownership passes between masters.
- Owner path:
  - s_cyc/stb/we/adr/dat_w/sel = owner's signals.
  - Owner's ack = s_ack, stall = s_stall, dat_r = s_dat_r.
  - In IDLE: s_cyc=s_stb=0, others 0.
- Non-owner: stall=1, ack=0, dat_r=0. Its stb is never forwarded.
- Grant is held while owner cyc=1, regardless of the other master's requests. There is no preemption.
- last is updated to the owner index on each OWNx entry.
- outstanding:
  - +1 on s_stb & !s_stall; -1 on s_ack; both together leave it unchanged.
  - Cleared on ownership change.
  - Saturates at 255 and does not wrap below 0.
  - An ack with outstanding=0 is ignored.
- Starvation counter per master:
  - Increments while that master's cyc=1 and it is not owner.
  - Cleared when it becomes owner or drops cyc.
  - Reaching STARVE_MAX sets starve[i]. The flag is sticky until reset; the counter saturates.
- Masters must not drop cyc while outstanding != 0. This is a protocol requirement; the bench checks it with an assertion, and the RTL does not enforce it.
- The arbiter is fully combinational from owner to slave, so there is no added bus latency beyond the grant.

Decomposition:
- Package wshb_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t
  - localparams for default AW/DW/STARVE_MAX
- Sub-module rr_picker2: a combinational 2-way round-robin selector (req[1:0], last -> winner, valid). It is instantiated once.
- Starvation counters stay inline in wshb_arbiter.

Test Plan:
- Reset then m0_cyc=1 alone at cycle 5 -> grant=01 at cycle 6; m1_stall=1, m1_ack=0 throughout.
- m0 and m1 raise cyc in the same cycle after reset -> grant=01 first. When m0 drops cyc, grant=10 on the next edge with no IDLE cycle; on the next tie, m0 wins again.
- Owner m1 issues 4 pipelined strobes, slave stalls 2 cycles and acks with 3-cycle latency -> outstanding goes 1,2,3,4 then down to 0; only m1 sees the acks; s_adr tracks m1_adr.
- m0 holds cyc for 5000 cycles while m1 requests with STARVE_MAX=4096 -> starve=10 after 4096 waiting cycles; the flag stays set after m1 is granted.
- Assert rst_n=0 for 1 cycle mid-burst with outstanding=3 -> next cycle grant=00, outstanding=0, s_cyc=0, both m*_stall=1.
- Single cycle with s_stb&!s_stall and s_ack together at outstanding=2 -> outstanding stays 2; an ack at outstanding=0 leaves it 0.
